// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the switch-driven LED mode controller.
// Holds the mode encoding, the per-mode state record and its helper functions.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    localparam logic [3:0] CHASE_INIT             = 4'b0001;
    localparam int         DEFAULT_DEBOUNCE_LIMIT = 250000;
    localparam int         DEFAULT_STEP_CYCLES    = 6250000;

    // Complete architectural state of the sequencer, visible as one record.
    typedef struct packed {
        mode_e      mode;
        logic [2:0] toggle;     // LED4..LED2 in TOGGLE mode
        logic [3:0] chase_pat;  // one-hot, LED4..LED1
        logic       chase_up;
        logic       chase_run;
        logic [3:0] count;
    } ctrl_state_t;

    function automatic ctrl_state_t state_init(input mode_e mode);
        ctrl_state_t s;
        s.mode      = mode;
        s.toggle    = '0;
        s.chase_pat = CHASE_INIT;
        s.chase_up  = 1'b1;
        s.chase_run = 1'b1;
        s.count     = '0;
        return s;
    endfunction

    function automatic mode_e next_mode(input mode_e mode);
        mode_e n;
        case (mode)
            MODE_PASS:   n = MODE_TOGGLE;
            MODE_TOGGLE: n = MODE_CHASE;
            MODE_CHASE:  n = MODE_COUNT;
            default:     n = MODE_PASS;
        endcase
        return n;
    endfunction

    // Up moves LED1->LED2->LED3->LED4->LED1; down is the reverse.
    function automatic logic [3:0] chase_rotate(input logic [3:0] pat, input logic up);
        return up ? {pat[2:0], pat[3]} : {pat[0], pat[3:1]};
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability counter for one raw switch.
// Emits the filtered level and a single-cycle pulse on each 1->0 transition.
module debounce_filter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Level,
    output logic o_Release
);

    localparam int              CW       = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          rel_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= i_Raw;
            sync_q <= meta_q;
            rel_q  <= 1'b0;
            // Any sample that agrees with the filtered level restarts the count.
            if (sync_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync_q;
                    cnt_q   <= '0;
                    rel_q   <= level_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign o_Level   = level_q;
    assign o_Release = rel_q;

endmodule

// File: rtl/switch_led_mode_ctrl.sv
// Shares the four board LEDs between PASS, TOGGLE, CHASE and COUNT modes.
// Switch 1 release cycles the mode; switches 2-4 releases are per-mode commands.
module switch_led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int STEP_CYCLES    = DEFAULT_STEP_CYCLES
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    output logic o_LED_1,
    output logic o_LED_2,
    output logic o_LED_3,
    output logic o_LED_4
);

    localparam int                STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] rel;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        debounce_filter #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_deb (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_Raw    (raw[g]),
            .o_Level  (level[g]),
            .o_Release(rel[g])
        );
    end

    ctrl_state_t       st_q;
    ctrl_state_t       st_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [3:0]        leds_q;
    logic [3:0]        leds_d;

    always_comb begin
        st_d   = st_q;
        step_d = step_q;
        leds_d = '0;

        // A mode change swallows any command released in the same cycle.
        if (rel[0]) begin
            st_d   = state_init(next_mode(st_q.mode));
            step_d = '0;
        end else begin
            case (st_q.mode)
                MODE_TOGGLE: begin
                    st_d.toggle = st_q.toggle ^ rel[3:1];
                end
                MODE_CHASE: begin
                    if (rel[1]) begin
                        st_d.chase_up = ~st_q.chase_up;
                    end
                    if (rel[3]) begin
                        st_d.chase_pat = CHASE_INIT;
                        st_d.chase_run = 1'b1;
                        step_d         = '0;
                    end else begin
                        // The step in progress still uses the old direction.
                        if (st_q.chase_run) begin
                            if (step_q == STEP_LAST) begin
                                step_d         = '0;
                                st_d.chase_pat = chase_rotate(st_q.chase_pat, st_q.chase_up);
                            end else begin
                                step_d = step_q + 1'b1;
                            end
                        end
                        if (rel[2]) begin
                            st_d.chase_run = ~st_q.chase_run;
                        end
                    end
                end
                MODE_COUNT: begin
                    if (rel[3]) begin
                        st_d.count = '0;
                    end else if (rel[1]) begin
                        st_d.count = st_q.count + 4'd1;
                    end else if (rel[2]) begin
                        st_d.count = st_q.count - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end

        case (st_d.mode)
            MODE_PASS:   leds_d = level;
            MODE_TOGGLE: leds_d = {st_d.toggle, 1'b0};
            MODE_CHASE:  leds_d = st_d.chase_pat;
            MODE_COUNT:  leds_d = st_d.count;
            default:     leds_d = '0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            st_q   <= state_init(MODE_PASS);
            step_q <= '0;
            leds_q <= '0;
        end else begin
            st_q   <= st_d;
            step_q <= step_d;
            leds_q <= leds_d;
        end
    end

    assign o_LED_1 = leds_q[0];
    assign o_LED_2 = leds_q[1];
    assign o_LED_3 = leds_q[2];
    assign o_LED_4 = leds_q[3];

endmodule
